// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 matrix multiply controller.
// Matrix memory holds A, B and the result C, addressed by (matrix, row, col).
package matrix_pkg;

  localparam int DIM    = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] MAT_A    = 2'd0;
  localparam logic [1:0] MAT_B    = 2'd1;
  localparam logic [1:0] MAT_C    = 2'd2;
  localparam logic [1:0] LAST_IDX = 2'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/matrix_mac.sv
// Multiply-accumulate datapath: holds the A operand, forms the 8x8 product
// and keeps the 18-bit running dot product for one C element.
module matrix_mac
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_a,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] rdata,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  logic [DATA_W-1:0] a_reg;
  logic [PROD_W-1:0] prod;

  assign prod = PROD_W'(a_reg) * PROD_W'(rdata);
  // sum is exposed so the controller can register the final element value
  // on the same edge that the last product is accumulated.
  assign sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      acc   <= '0;
    end else begin
      if (load_a) a_reg <= rdata;
      if (clear)       acc <= '0;
      else if (acc_en) acc <= sum;
    end
  end

endmodule

// File: rtl/matrix_mult_ctrl.sv
// Controller computing C = A x B over a shared 3x3 matrix memory, one memory
// access per cycle; all memory-side outputs are registered alongside the state.
module matrix_mult_ctrl
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [1:0]        mem_matrix_select,
  output logic [1:0]        mem_row,
  output logic [1:0]        mem_col,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output state_t            state
);

  // Memory handshake: no valid/ready; the address registered on entry to a
  // state is live for that whole cycle and read data returns in the same cycle.
  logic [1:0]       i;
  logic [1:0]       j;
  logic [1:0]       k;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             mac_clear;
  logic             mac_load_a;
  logic             mac_acc_en;

  assign mac_clear  = (state == WR) || ((state == IDLE) && start);
  assign mac_load_a = (state == RD_A);
  assign mac_acc_en = (state == RD_B);

  matrix_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .load_a (mac_load_a),
    .acc_en (mac_acc_en),
    .rdata  (mem_read_data),
    .acc    (acc),
    .sum    (sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      i                 <= '0;
      j                 <= '0;
      k                 <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      overflow          <= 1'b0;
      mem_matrix_select <= '0;
      mem_row           <= '0;
      mem_col           <= '0;
      mem_write_enable  <= 1'b0;
      mem_write_data    <= '0;
    end else begin
      done             <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= RD_A;
            i                 <= '0;
            j                 <= '0;
            k                 <= '0;
            overflow          <= 1'b0;
            busy              <= 1'b1;
            mem_matrix_select <= MAT_A;
            mem_row           <= '0;
            mem_col           <= '0;
          end else begin
            busy              <= 1'b0;
            mem_matrix_select <= '0;
            mem_row           <= '0;
            mem_col           <= '0;
          end
        end
        RD_A: begin
          state             <= RD_B;
          mem_matrix_select <= MAT_B;
          mem_row           <= k;
          mem_col           <= j;
        end
        RD_B: begin
          if (k == LAST_IDX) begin
            state             <= WR;
            k                 <= '0;
            mem_matrix_select <= MAT_C;
            mem_row           <= i;
            mem_col           <= j;
            mem_write_enable  <= 1'b1;
            mem_write_data    <= sum[DATA_W-1:0];
          end else begin
            state             <= RD_A;
            k                 <= k + 2'd1;
            mem_matrix_select <= MAT_A;
            mem_row           <= i;
            mem_col           <= k + 2'd1;
          end
        end
        WR: begin
          if (acc > ACC_W'(255)) overflow <= 1'b1;
          if (j == LAST_IDX) begin
            j <= '0;
            if (i == LAST_IDX) begin
              state             <= DONE;
              i                 <= '0;
              busy              <= 1'b0;
              done              <= 1'b1;
              mem_matrix_select <= '0;
              mem_row           <= '0;
              mem_col           <= '0;
            end else begin
              state             <= RD_A;
              i                 <= i + 2'd1;
              mem_matrix_select <= MAT_A;
              mem_row           <= i + 2'd1;
              mem_col           <= '0;
            end
          end else begin
            state             <= RD_A;
            j                 <= j + 2'd1;
            mem_matrix_select <= MAT_A;
            mem_row           <= i;
            mem_col           <= '0;
          end
        end
        DONE: begin
          // start is deliberately not sampled here; only IDLE accepts it.
          state             <= IDLE;
          busy              <= 1'b0;
          mem_matrix_select <= '0;
          mem_row           <= '0;
          mem_col           <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
